// File: rtl/riscv_data_mem_responder_if.sv
// Request/response bus between the core's load/store path (master) and the
// data-memory responder (slave).
interface riscv_data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_memop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_memop, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_memop, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/riscv_data_mem_responder.sv
// Fixed-latency data-memory responder: one outstanding load/store, byte-lane
// masked word RAM, result returned over a valid/ready response channel.
module riscv_data_mem_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h80000000,
  parameter int          LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  riscv_data_mem_responder_if.slave       bus
);

  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wen_q, wen_d;
  logic [2:0]    memop_q, memop_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   ram [DEPTH];

  logic          acc_wen;
  logic [2:0]    acc_memop;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic          acc_signed;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wword;
  logic [31:0]   acc_rword;
  logic [31:0]   acc_shift;
  logic [31:0]   acc_rdata;
  logic          enter_resp;
  logic          ram_we;

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // With LATENCY==1 the access edge is the handshake edge, so the access
  // must be decoded straight from the bus rather than from the latch.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_wen   = bus.req_wen;
      acc_memop = bus.req_memop;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_wen   = wen_q;
      acc_memop = memop_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end

    acc_signed = ~acc_memop[2];
    case (acc_memop)
      3'b000, 3'b100: acc_size = 2'd0;
      3'b001, 3'b101: acc_size = 2'd1;
      3'b010:         acc_size = 2'd2;
      default:        acc_size = 2'd3;
    endcase

    acc_err = (acc_size == 2'd3)
           || ((acc_size == 2'd1) && acc_addr[0])
           || ((acc_size == 2'd2) && (acc_addr[1:0] != 2'b00))
           || (acc_addr < BASE)
           || ({1'b0, acc_addr} >= LIMIT);

    acc_idx = AW'((acc_addr - BASE) >> 2);

    case (acc_size)
      2'd0: begin
        acc_be    = 4'b0001 << acc_addr[1:0];
        acc_wword = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        acc_wword = {2{acc_wdata[15:0]}};
      end
      2'd2: begin
        acc_be    = 4'b1111;
        acc_wword = acc_wdata;
      end
      default: begin
        acc_be    = 4'b0000;
        acc_wword = acc_wdata;
      end
    endcase

    acc_rword = ram[acc_idx];
    acc_shift = acc_rword >> {acc_addr[1:0], 3'b000};
    case (acc_size)
      2'd0:    acc_rdata = {{24{acc_signed & acc_shift[7]}}, acc_shift[7:0]};
      2'd1:    acc_rdata = {{16{acc_signed & acc_shift[15]}}, acc_shift[15:0]};
      default: acc_rdata = acc_rword;
    endcase
    if (acc_err || acc_wen) begin
      acc_rdata = 32'h0;
    end
  end

  assign enter_resp = ((state_q == S_IDLE) && bus.req_valid && (LATENCY == 1))
                   || ((state_q == S_WAIT) && (cnt_q == '0));
  // RAM has no reset, so gate the write with rst to keep reset from committing.
  assign ram_we     = enter_resp && rst && acc_wen && !acc_err;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          ram[acc_idx][8*i +: 8] <= acc_wword[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    memop_d = memop_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wen_d   = bus.req_wen;
          memop_d = bus.req_memop;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            rdata_d = acc_rdata;
            err_d   = acc_err;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          rdata_d = acc_rdata;
          err_d   = acc_err;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      memop_q <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      memop_q <= memop_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// Bench for riscv_data_mem_responder: directed and random accesses against a
// byte-addressed reference model; LATENCY=2 and LATENCY=1 instances.
module tb_riscv_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          sel;
  logic        req_valid, req_wen, rsp_ready;
  logic [2:0]  req_memop;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [31:0] rsp_rdata_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] mb [int];

  riscv_data_mem_responder_if bus0 ();
  riscv_data_mem_responder_if bus1 ();

  assign bus0.req_valid = req_valid & ~sel;
  assign bus1.req_valid = req_valid & sel;
  assign bus0.req_wen   = req_wen;
  assign bus1.req_wen   = req_wen;
  assign bus0.req_memop = req_memop;
  assign bus1.req_memop = req_memop;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;
  assign bus0.rsp_ready = rsp_ready;
  assign bus1.rsp_ready = rsp_ready;

  assign req_ready_s = sel ? bus1.req_ready : bus0.req_ready;
  assign rsp_valid_s = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign rsp_rdata_s = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
  assign rsp_err_s   = sel ? bus1.rsp_err   : bus0.rsp_err;

  riscv_data_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  riscv_data_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int key(input bit s, input longint off);
    return (s ? 32'h4000_0000 : 0) + int'(off);
  endfunction

  // Byte-addressed memory semantics, little-endian.
  task automatic model(input bit s, input bit wen, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er);
    int          size;
    bit          sgn;
    longint      off;
    logic [31:0] v;
    rd = 32'h0;
    er = 1'b0;
    case (op)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    sgn = (op == 3'd0) || (op == 3'd1);
    off = longint'({32'b0, a}) - longint'({32'b0, BASE});
    if (size == 0 || (int'(a[1:0]) % size) != 0 || off < 0 || off >= 4 * DEPTH) begin
      er = 1'b1;
      return;
    end
    if (wen) begin
      for (int i = 0; i < size; i++) mb[key(s, off + i)] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[key(s, off + i)];
      if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd = v;
    end
  endtask

  task automatic start(input bit wen, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    req_wen   = wen;
    req_memop = op;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready_s) break;
    end
    chk("req_ready_hs", req_ready_s, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid_s) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic xact(input bit s, input bit wen, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] wd,
                      input string tag, output logic [31:0] rd);
    logic [31:0] erd;
    bit          eer;
    int          lat;
    sel = s;
    model(s, wen, op, a, wd, erd, eer);
    start(wen, op, a, wd);
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, s ? 1 : 2);
    chk({tag, "_rdata"}, rsp_rdata_s, erd);
    chk({tag, "_err"}, rsp_err_s, eer);
    rd = rsp_rdata_s;
    $display("xact %s dut%0d wen=%0d op=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             tag, s, wen, op, a, wd, rsp_rdata_s, rsp_err_s, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd, erd, r0, a;
    logic [31:0] edges [8];
    logic [31:0] tp_exp [8];
    bit          eer, e0, acc;
    int          lat, nrsp, idx, last;

    sel = 0; req_valid = 0; req_wen = 0; req_memop = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 1;

    // Reset values
    #1 rst = 1'b0;
    #11;
    chk("rst_req_ready", bus0.req_ready, 1);
    chk("rst_rsp_valid", bus0.rsp_valid, 0);
    chk("rst_rsp_rdata", bus0.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   bus0.rsp_err, 0);
    chk("rst1_rsp_valid", bus1.rsp_valid, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Fill the low 256 bytes so every later load reads defined data
    for (int i = 0; i < 64; i++) xact(0, 1, 3'd2, BASE + 32'(4*i), $urandom, "fill", rd);

    // Word round trip
    xact(0, 1, 3'd2, 32'h80000010, 32'hDEADBEEF, "sw_rt", rd);
    xact(0, 0, 3'd2, 32'h80000010, 32'h0, "lw_rt", rd);
    chk("lw_rt_const", rd, 32'hDEADBEEF);

    // Sub-word stores and extension
    xact(0, 1, 3'd2, 32'h80000020, 32'h0, "sw_zero", rd);
    xact(0, 1, 3'd0, 32'h80000023, 32'h12345680, "sb", rd);
    xact(0, 1, 3'd1, 32'h80000020, 32'hABCD8001, "sh", rd);
    xact(0, 0, 3'd2, 32'h80000020, 32'h0, "lw_sub", rd);
    chk("lw_sub_const", rd, 32'h80008001);
    xact(0, 0, 3'd0, 32'h80000023, 32'h0, "lb", rd);
    chk("lb_const", rd, 32'hFFFFFF80);
    xact(0, 0, 3'd4, 32'h80000023, 32'h0, "lbu", rd);
    chk("lbu_const", rd, 32'h00000080);
    xact(0, 0, 3'd1, 32'h80000020, 32'h0, "lh", rd);
    chk("lh_const", rd, 32'hFFFF8001);
    xact(0, 0, 3'd5, 32'h80000020, 32'h0, "lhu", rd);
    chk("lhu_const", rd, 32'h00008001);

    // Misaligned, out-of-range, reserved memop
    xact(0, 0, 3'd2, 32'h80000002, 32'h0, "lw_mis", rd);
    xact(0, 1, 3'd1, 32'h80000001, 32'h0000BEEF, "sh_mis", rd);
    xact(0, 1, 3'd2, 32'h80001000, 32'h12345678, "sw_oor", rd);
    xact(0, 1, 3'd3, 32'h80000004, 32'hCAFEF00D, "st_rsv", rd);
    xact(0, 0, 3'd3, 32'h80000004, 32'h0, "ld_rsv", rd);
    xact(0, 0, 3'd2, 32'h7FFFFFFC, 32'h0, "lw_below", rd);
    xact(0, 0, 3'd2, 32'h80000000, 32'h0, "rb_w0", rd);
    xact(0, 0, 3'd2, 32'h80000004, 32'h0, "rb_w1", rd);
    xact(0, 1, 3'd2, 32'h80000FFC, 32'h5A5AC3C3, "sw_last", rd);
    xact(0, 0, 3'd2, 32'h80000FFC, 32'h0, "lw_last", rd);

    // Back-pressure: outputs hold, inputs ignored
    rsp_ready = 1'b0;
    model(0, 0, 3'd2, 32'h80000010, 32'h0, r0, e0);
    start(0, 3'd2, 32'h80000010, 32'h0);
    wait_rsp(lat);
    chk("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req_valid = ~req_valid;
      req_addr  = BASE + 32'($urandom_range(0, 255));
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid_s, 1);
      chk("bp_rsp_rdata", rsp_rdata_s, r0);
      chk("bp_rsp_err",   rsp_err_s, e0);
      chk("bp_req_ready", req_ready_s, 0);
      $display("bp cycle %0d rsp_valid=%0d rdata=%h req_ready=%0d", i, rsp_valid_s, rsp_rdata_s, req_ready_s);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_memop = 3'd2; req_addr = 32'h80000020;
    model(0, 0, 3'd2, 32'h80000020, 32'h0, erd, eer);
    @(negedge clk);
    chk("bp_release_ready", req_ready_s, 0);
    chk("bp_release_valid", rsp_valid_s, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_next_ready", req_ready_s, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp_next_lat", lat, 2);
    chk("bp_next_rdata", rsp_rdata_s, erd);
    $display("bp next request rdata=%h lat=%0d", rsp_rdata_s, lat);
    @(posedge clk); #1;

    // Reset during WAIT abandons a store
    xact(0, 1, 3'd2, 32'h80000040, 32'h11111111, "sw_old", rd);
    start(1, 3'd2, 32'h80000040, 32'hA5A5A5A5);
    chk("wait_rsp_valid", rsp_valid_s, 0);
    rst = 1'b0;
    #1;
    chk("rstw_req_ready", req_ready_s, 1);
    chk("rstw_rsp_valid", rsp_valid_s, 0);
    chk("rstw_rsp_rdata", rsp_rdata_s, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    xact(0, 0, 3'd2, 32'h80000040, 32'h0, "lw_after_rstw", rd);
    chk("lw_after_rstw_const", rd, 32'h11111111);

    // Reset during RESP keeps the committed store
    rsp_ready = 1'b0;
    model(0, 1, 3'd2, 32'h80000044, 32'h22222222, erd, eer);
    start(1, 3'd2, 32'h80000044, 32'h22222222);
    wait_rsp(lat);
    chk("rstr_lat", lat, 2);
    rst = 1'b0;
    #1;
    chk("rstr_rsp_valid", rsp_valid_s, 0);
    @(negedge clk) rst = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    xact(0, 0, 3'd2, 32'h80000044, 32'h0, "lw_after_rstr", rd);
    chk("lw_after_rstr_const", rd, 32'h22222222);

    // Random traffic including boundary addresses
    edges[0] = 32'h7FFFFFFF; edges[1] = 32'h7FFFFFFC; edges[2] = 32'h80001000;
    edges[3] = 32'h80000FFC; edges[4] = 32'h80000FFE; edges[5] = 32'h80000FFF;
    edges[6] = 32'h00000000; edges[7] = 32'hFFFFFFFC;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) a = edges[$urandom_range(0, 7)];
      else a = BASE + 32'($urandom_range(0, 255));
      xact(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rnd", rd);
    end

    // Back-to-back throughput on the LATENCY=1 instance
    for (int i = 0; i < 8; i++) xact(1, 1, 3'd2, BASE + 32'(8*i), {8'(i), 24'($urandom)}, "tp_fill", rd);
    for (int i = 0; i < 8; i++) model(1, 0, 3'd2, BASE + 32'(8*i), 32'h0, tp_exp[i], eer);
    sel = 1; rsp_ready = 1'b1;
    idx = 0; nrsp = 0; last = 0;
    req_wen = 1'b0; req_memop = 3'd2; req_addr = BASE; req_valid = 1'b1;
    for (int c = 0; c < 60 && nrsp < 8; c++) begin
      @(negedge clk);
      acc = req_valid && req_ready_s;
      if (rsp_valid_s) begin
        chk("tp_rdata", rsp_rdata_s, tp_exp[nrsp]);
        chk("tp_err", rsp_err_s, 0);
        if (nrsp > 0) chk("tp_spacing", cyc - last, 2);
        $display("tp rsp %0d rdata=%h cyc=%0d", nrsp, rsp_rdata_s, cyc);
        last = cyc;
        nrsp++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 8) req_addr = BASE + 32'(8*idx);
        else req_valid = 1'b0;
      end
    end
    chk("tp_count", nrsp, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
